cyber_player: RTL and testbench
===============================

# cyber_player

Computer opponent for the tug-of-war game. Instead of reading a player's key, it generates the key-press pulse itself. It drives the same single-cycle `L`/`R` press input of the light and display FSMs that a debounced human key drives, and replaces one human player. Press probability per decision tick is set by a 10-bit difficulty value taken from the switches. Randomness comes from an LFSR.

## Interface
Parameters:
- `LFSR_W`, default 10: LFSR and difficulty width.
- `DIV_W`, default 23: tick divider width. One decision every 2^DIV_W clocks, about 6 Hz at 50 MHz. Benches use 2.

Ports:
- `Clock`, input, 1: system clock, CLOCK_50.
- `Reset`, input, 1: one clock; reset is asynchronous and active-high.
- `enable`, input, 1: game running. Low suppresses presses, for example once the display shows a winner.
- `difficulty`, input, LFSR_W: raw switch value, asynchronous to Clock. 0 never presses; all-ones presses every tick.
- `press`, output, 1: single-cycle press pulse. Connects where a human key's press pulse would.
- `lfsr_q`, output, LFSR_W: current LFSR state, for observability.

## Operation
- **Difficulty synchronizer.** Two-flop synchronizer, `difficulty` → `diff_s`.
- **Tick counter.**
  - `div_q` is a DIV_W-bit free-running up-counter. It wraps from all-ones to 0.
  - `tick` = (`div_q` == all-ones). This is combinational, one cycle wide.
- **LFSR.**
  - XNOR Fibonacci form, polynomial x^10 + x^7 + 1.
  - Next state = {q[8:0], ~(q[9] ^ q[6])}.
  - Advances only on a tick edge. It advances regardless of `enable`.
  - Period is 1023. The all-ones lock-up state is unreachable from reset.
  - Sequence from reset: 000, 001, 003, 007, 00F, 01F, 03F, 07F, 0FE, 1FC, …
- **Decision, on a tick edge.**
  - `press` <= `enable` & (`lfsr_q` < `diff_s`). The compare is unsigned, LFSR_W bits, and uses the pre-advance `lfsr_q`.
  - Because the LFSR never reaches 3FF, difficulty 3FF presses on every tick.
- **Non-tick edges.** `press` <= 0. The pulse is therefore exactly one cycle, with at most one pulse per tick period.
- **No state machine beyond the registers.** Behaviour is fully determined by `div_q`, `lfsr_q`, the two sync stages and `press`.

## Timing
- **Reset values** (asserted asynchronously, immediately on `Reset` rising):
  - `press` = 0.
  - `lfsr_q` = 0.
  - `div_q` = 0.
  - Sync flops = 0.
- **Reset release.** Counting starts at the first rising edge after `Reset` falls.
- **First decision.**
  - The first tick occurs in cycle 2^DIV_W − 1 after release.
  - `press` is high during cycle 2^DIV_W. That first decision compares `lfsr_q` = 000.
- **Press latency.** One clock from the tick cycle to `press` high.
- **Difficulty latency.** A `difficulty` change takes effect in decisions at least 2 edges later. Changes within 2 cycles of a tick may use the old value.
- **`enable` latency.** `enable` is sampled directly at the tick edge and is not synchronized; it comes from in-domain FSMs.
- **Reset mid-pulse.** `press` drops immediately with no completion cycle.

## Structure
- **Package `tow_pkg`:**
  - `LFSR_W`.
  - The tap positions, 9 and 6.
  - `LFSR_SEED` = 0.
  - Press pulse semantics, shared with the human-key edge detector.
- **Sub-module `lfsr`:**
  - Ports: Clock, Reset, advance, q.
  - Owns the XNOR feedback and the async reset to seed.
- **Top-level `cyber_player`:** holds the synchronizer, the divider, the comparator and the `press` register.

## Test plan
All scenarios use DIV_W=2, so a tick occurs every 4 cycles.
- **Never presses:** difficulty=000, enable=1, 1000 cycles → `press` never high; `lfsr_q` follows 000, 001, 003, 007, … one step per 4 cycles.
- **Presses every tick:** difficulty=3FF, enable=1 → `press` high exactly 1 cycle in every 4; first pulse in cycle 4 after release.
- **Threshold:** difficulty=010 → pulses on ticks 1–5 (lfsr 000, 001, 003, 007, 00F); no pulse on ticks 6–8 (01F, 03F, 07F).
- **Enable low:** enable=0, difficulty=3FF → `press` stays 0 while `lfsr_q` still advances each tick; raising enable → pulse at the next tick.
- **Reset mid-pulse:** assert `Reset` asynchronously, mid-cycle, while `press`=1 → `press` and `lfsr_q` go to 0 before the next edge; after release, the sequence restarts at 000.
- **Difficulty change:** step difficulty 000→3FF 1 cycle before a tick → no pulse on that tick; pulse on the following tick.

Source files
------------

// File: rtl/tow_pkg.sv
// Shared definitions for the tug-of-war game: LFSR geometry, seed and
// the press-pulse contract used by both the human key path and the computer opponent.
package tow_pkg;

  localparam int LFSR_WIDTH = 10;

  // Feedback taps for x^10 + x^7 + 1 in XNOR Fibonacci form.
  localparam int TAP_HI = 9;
  localparam int TAP_LO = 6;

  // All-zeros is a legal state for the XNOR form; all-ones is the lock-up state.
  localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = '0;

  // A press is a single-cycle, active-high pulse. The light and display FSMs
  // count one move per high cycle, so a source must never hold it for two cycles.
  localparam int PRESS_PULSE_CYCLES = 1;

endpackage

// File: rtl/lfsr.sv
// XNOR Fibonacci LFSR that steps only when advance is high;
// asynchronous reset loads the package seed.
module lfsr
  import tow_pkg::*;
#(
  parameter int W = LFSR_WIDTH
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         advance,
  output logic [W-1:0] q
);

  logic feedback;

  // XNOR keeps the all-zeros seed moving and parks the lock-up at all-ones.
  assign feedback = ~(q[TAP_HI] ^ q[TAP_LO]);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      q <= W'(LFSR_SEED);
    end else if (advance) begin
      q <= {q[W-2:0], feedback};
    end
  end

endmodule

// File: rtl/cyber_player.sv
// Computer opponent: emits a one-cycle press pulse on a decision tick when
// the LFSR value is below the synchronized difficulty and the game is enabled.
module cyber_player
  import tow_pkg::*;
#(
  parameter int LFSR_W = LFSR_WIDTH,
  parameter int DIV_W  = 23
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              enable,
  input  logic [LFSR_W-1:0] difficulty,
  output logic              press,
  output logic [LFSR_W-1:0] lfsr_q
);

  logic [LFSR_W-1:0] diff_meta;
  logic [LFSR_W-1:0] diff_s;
  logic [DIV_W-1:0]  div_q;
  logic              tick;
  logic              press_d;

  // Switches are asynchronous to Clock; two flops before the comparator.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      diff_meta <= '0;
      diff_s    <= '0;
    end else begin
      diff_meta <= difficulty;
      diff_s    <= diff_meta;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign tick = &div_q;

  lfsr #(
    .W(LFSR_W)
  ) u_lfsr (
    .Clock   (Clock),
    .Reset   (Reset),
    .advance (tick),
    .q       (lfsr_q)
  );

  // The compare sees the pre-advance LFSR value; since all-ones is never
  // reached, an all-ones difficulty fires on every tick.
  always_comb begin
    press_d = 1'b0;
    if (tick && enable && (lfsr_q < diff_s)) begin
      press_d = 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      press <= 1'b0;
    end else begin
      press <= press_d;
    end
  end

endmodule

// File: tb/tb_cyber_player.sv
// Directed bench for cyber_player with DIV_W=2 (a tick every 4 cycles).
module tb_cyber_player;

  localparam int W = 10;

  logic         Clock;
  logic         Reset;
  logic         enable;
  logic [W-1:0] difficulty;
  logic         press;
  logic [W-1:0] lfsr_q;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int cyc    = 0;

  // LFSR states after each tick, starting at reset.
  logic [W-1:0] seq_tab [0:9] = '{10'h000, 10'h001, 10'h003, 10'h007, 10'h00F,
                                  10'h01F, 10'h03F, 10'h07F, 10'h0FE, 10'h1FC};

  cyber_player #(
    .LFSR_W (W),
    .DIV_W  (2)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .enable     (enable),
    .difficulty (difficulty),
    .press      (press),
    .lfsr_q     (lfsr_q)
  );

  // Clock / reset block
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one clock and settle past the edge; cyc counts edges since release.
  task automatic next_cycle();
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    cyc = 0;
  endtask

  initial begin
    Reset      = 1'b1;
    enable     = 1'b1;
    difficulty = 10'h000;
    #2;
    check("reset_press", {9'b0, press}, 10'h000);
    check("reset_lfsr", lfsr_q, 10'h000);

    // Never presses: difficulty 000
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      next_cycle();
      check("d000_press", {9'b0, press}, 10'h000);
      if (cyc < 40) check("d000_lfsr", lfsr_q, seq_tab[cyc / 4]);
    end

    // Presses every tick: difficulty 3FF
    difficulty = 10'h3FF;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      check("d3ff_press", {9'b0, press}, (cyc % 4 == 0) ? 10'h001 : 10'h000);
    end

    // Threshold: difficulty 010 fires on ticks 1-5 only
    difficulty = 10'h010;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      next_cycle();
      check("thresh_press", {9'b0, press},
            ((cyc % 4 == 0) && (cyc / 4 <= 5)) ? 10'h001 : 10'h000);
      check("thresh_lfsr", lfsr_q, seq_tab[cyc / 4]);
    end

    // Enable low: no presses, LFSR still advances
    enable     = 1'b0;
    difficulty = 10'h3FF;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      next_cycle();
      check("en0_press", {9'b0, press}, 10'h000);
      check("en0_lfsr", lfsr_q, seq_tab[cyc / 4]);
    end
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      check("en1_press", {9'b0, press}, (cyc == 28) ? 10'h001 : 10'h000);
    end

    // Reset mid-pulse: press is high in cycle 28 here
    #2;
    Reset = 1'b1;
    #1;
    check("rst_mid_press", {9'b0, press}, 10'h000);
    check("rst_mid_lfsr", lfsr_q, 10'h000);
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      check("restart_lfsr", lfsr_q, seq_tab[cyc / 4]);
      check("restart_press", {9'b0, press}, (cyc % 4 == 0) ? 10'h001 : 10'h000);
    end

    // Difficulty change one cycle before the tick in cycle 7
    difficulty = 10'h000;
    do_reset();
    for (int i = 0; i < 6; i++) next_cycle();
    difficulty = 10'h3FF;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      check("dchg_press", {9'b0, press}, (cyc == 12) ? 10'h001 : 10'h000);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
